// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and sizing helpers for the trace capture block
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } trace_state_e;

  localparam int DROP_CNT_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TS_W   = 32;

  // Entry layout for the default widths; the FIFO stores the same {ts, data} packing.
  typedef struct packed {
    logic [DEF_TS_W-1:0]   ts;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_w(input int data_w, input int ts_w);
    return data_w + ts_w;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - event input and FWFT read port bundle
interface trace_capture_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;

  modport master (
    output evt_valid, evt_data, rd_ready,
    input  rd_valid, rd_data, rd_ts
  );

  modport slave (
    input  evt_valid, evt_data, rd_ready,
    output rd_valid, rd_data, rd_ts
  );
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through entry store with level tracking
module trace_fifo
  import trace_pkg::*;
#(
  parameter int W     = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          pop;

  // Pointer/level update; the caller only pushes below DEPTH, a pop needs a registered entry.
  always_comb begin
    pop     = (level_q != '0) && rd_ready;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end
  end

  // Control registers; storage is left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr_q] <= wr_data;
  end

  assign rd_valid = (level_q != '0);
  assign rd_data  = mem[rptr_q];
  assign level    = level_q;

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - timestamped event capture with drop counting and stop-on-full
module trace_capture
  import trace_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int TS_W         = 32,
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  trace_capture_if.slave         bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  output logic                   stopped
);
  localparam int LW = level_w(DEPTH);
  localparam int EW = entry_w(DATA_W, TS_W);

  trace_state_e          state_q, state_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  push;
  logic                  drop;
  logic                  full;
  logic [EW-1:0]         rd_entry;

  assign full = (level == LW'(DEPTH));

  // Capture FSM, timestamp and drop counter; clear overrides everything.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    drop_d  = drop_q;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        ts_d = ts_q + TS_W'(1);
        if (bus.evt_valid) begin
          if (full) drop = 1'b1;
          else      push = 1'b1;
        end
        if (drop && STOP_ON_FULL) state_d = STOPPED;
        else if (!en)             state_d = IDLE;
      end
      STOPPED: begin
        state_d = STOPPED;
      end
      default: state_d = IDLE;
    endcase
    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
    if (clear) begin
      state_d = IDLE;
      ts_d    = '0;
      drop_d  = '0;
    end
  end

  // State, timestamp and drop counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
    end
  end

  trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .wr_data  ({ts_q, bus.evt_data}),
    .rd_ready (bus.rd_ready),
    .rd_valid (bus.rd_valid),
    .rd_data  (rd_entry),
    .level    (level)
  );

  assign bus.rd_ts   = rd_entry[EW-1:DATA_W];
  assign bus.rd_data = rd_entry[DATA_W-1:0];
  assign drop_cnt    = drop_q;
  assign stopped     = (state_q == STOPPED);

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - randomized self-checking bench for trace_capture
module tb_trace_capture;

  logic        clk = 1'b0;
  logic        rst, en, clear, evt_valid, rd_ready;
  logic [15:0] evt_data;

  always #5 clk = ~clk;

  trace_capture_if #(.DATA_W(16), .TS_W(4))  bus0 ();
  trace_capture_if #(.DATA_W(16), .TS_W(32)) bus1 ();

  assign bus0.evt_valid = evt_valid;
  assign bus0.evt_data  = evt_data;
  assign bus0.rd_ready  = rd_ready;
  assign bus1.evt_valid = evt_valid;
  assign bus1.evt_data  = evt_data;
  assign bus1.rd_ready  = rd_ready;

  logic [4:0]  level0, level1;
  logic [15:0] dc0, dc1;
  logic        st0, st1;

  trace_capture #(.DATA_W(16), .TS_W(4), .DEPTH(16), .STOP_ON_FULL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .bus(bus0),
    .level(level0), .drop_cnt(dc0), .stopped(st0)
  );

  trace_capture #(.DATA_W(16), .TS_W(32), .DEPTH(16), .STOP_ON_FULL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .bus(bus1),
    .level(level1), .drop_cnt(dc1), .stopped(st1)
  );

  logic [4:0]  lvl  [2];
  logic        rv   [2];
  logic [15:0] rdat [2];
  logic [31:0] rts  [2];
  logic [15:0] dcnt [2];
  logic        stp  [2];

  always_comb begin
    lvl[0] = level0;        lvl[1] = level1;
    rv[0]  = bus0.rd_valid; rv[1]  = bus1.rd_valid;
    rdat[0] = bus0.rd_data; rdat[1] = bus1.rd_data;
    rts[0] = {28'd0, bus0.rd_ts};
    rts[1] = bus1.rd_ts;
    dcnt[0] = dc0;          dcnt[1] = dc1;
    stp[0] = st0;           stp[1] = st1;
  end

  // Behavioural model: a queue of captured entries per DUT plus capture mode.
  typedef struct {
    int unsigned ts;
    logic [15:0] data;
  } ent_t;

  ent_t        mq [2][$];
  int unsigned mts [2];
  int          mdrop [2];
  int          mmode [2];   // 0 disarmed, 1 capturing, 2 halted
  int unsigned tsmask [2] = '{32'h0000_000F, 32'hFFFF_FFFF};
  bit          sof [2] = '{1'b0, 1'b1};

  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      mts[d] = 0;
      mdrop[d] = 0;
      mmode[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int  pre;
      bit  full;
      bit  dropped;
      if (clear) begin
        mq[d].delete();
        mts[d] = 0;
        mdrop[d] = 0;
        mmode[d] = 0;
        continue;
      end
      pre = mmode[d];
      full = (mq[d].size() == 16);
      dropped = 1'b0;
      if (mq[d].size() != 0 && rd_ready) void'(mq[d].pop_front());
      if (pre == 1 && evt_valid) begin
        if (!full) mq[d].push_back('{mts[d], evt_data});
        else begin
          dropped = 1'b1;
          if (mdrop[d] < 65535) mdrop[d]++;
        end
      end
      case (pre)
        0: if (en) mmode[d] = 1;
        1: if (dropped && sof[d]) mmode[d] = 2;
           else if (!en) mmode[d] = 0;
        default: ;
      endcase
      if (pre == 1) mts[d] = (mts[d] + 1) & tsmask[d];
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; clear = 1'b0; evt_valid = 1'b0; rd_ready = 1'b0; evt_data = 16'h0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd0 || rv[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_level dut%0d: level %0d rd_valid %0b, expected 0 0", d, lvl[d], rv[d]);
      end
      vectors++;
      if (dcnt[d] !== 16'd0 || stp[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_cnt dut%0d: drop_cnt %0d stopped %0b, expected 0 0", d, dcnt[d], stp[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_data [3];
    exp_data[0] = 16'h0011; exp_data[1] = 16'h0022; exp_data[2] = 16'h0033;
    do_clear();
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      evt_valid = 1'b1;
      evt_data = exp_data[i];
      tick();
    end
    evt_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd3) begin
        miscompares++;
        $display("FAIL basic_level dut%0d: got %0d expected 3", d, lvl[d]);
      end
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (rv[d] !== 1'b1 || rdat[d] !== exp_data[i] || rts[d] !== 32'(i)) begin
          miscompares++;
          $display("FAIL basic_entry%0d dut%0d: got v=%0b %h ts=%0d expected 1 %h ts=%0d",
                   i, d, rv[d], rdat[d], rts[d], exp_data[i], i);
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd0 || rv[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_drain dut%0d: level %0d rd_valid %0b expected 0 0", d, lvl[d], rv[d]);
      end
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    logic [15:0] exp_data [20];
    do_clear();
    en = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      exp_data[i] = 16'($urandom);
      evt_valid = 1'b1;
      evt_data = exp_data[i];
      tick();
    end
    evt_valid = 1'b0;
    vectors++;
    if (lvl[0] !== 5'd16 || dcnt[0] !== 16'd4 || stp[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_dut0: level %0d drop %0d stopped %0b expected 16 4 0", lvl[0], dcnt[0], stp[0]);
    end
    vectors++;
    if (lvl[1] !== 5'd16 || dcnt[1] !== 16'd1 || stp[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_dut1: level %0d drop %0d stopped %0b expected 16 1 1", lvl[1], dcnt[1], stp[1]);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (rdat[d] !== exp_data[i] || rts[d] !== (32'(i) & tsmask[d])) begin
          miscompares++;
          $display("FAIL overflow_read%0d dut%0d: got %h ts=%0d expected %h ts=%0d",
                   i, d, rdat[d], rts[d], exp_data[i], 32'(i) & tsmask[d]);
        end
      end
      tick();
    end
    rd_ready = 1'b0;
    en = 1'b0;
    do_clear();
    vectors++;
    if (stp[1] !== 1'b0 || lvl[1] !== 5'd0 || dcnt[1] !== 16'd0) begin
      miscompares++;
      $display("FAIL stop_clear dut1: stopped %0b level %0d drop %0d expected 0 0 0", stp[1], lvl[1], dcnt[1]);
    end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    en = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      evt_valid = 1'b1;
      evt_data = 16'(i + 16'h100);
      tick();
    end
    evt_valid = 1'b1;
    evt_data = 16'hDEAD;
    rd_ready = 1'b1;
    tick();
    evt_valid = 1'b0;
    rd_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd15 || dcnt[d] !== 16'd1 || stp[d] !== sof[d]) begin
        miscompares++;
        $display("FAIL full_push_pop dut%0d: level %0d drop %0d stopped %0b expected 15 1 %0b",
                 d, lvl[d], dcnt[d], stp[d], sof[d]);
      end
      vectors++;
      if (rdat[d] !== 16'h101) begin
        miscompares++;
        $display("FAIL full_push_pop_head dut%0d: got %h expected 0101", d, rdat[d]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    do_clear();
    en = 1'b1;
    tick();
    evt_valid = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      evt_data = 16'(k);
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (lvl[d] !== 5'd1 || rdat[d] !== 16'(k) || rts[d] !== (32'(k) & tsmask[d])) begin
          miscompares++;
          $display("FAIL wrap%0d dut%0d: level %0d data %h ts %0d expected 1 %h %0d",
                   k, d, lvl[d], rdat[d], rts[d], 16'(k), 32'(k) & tsmask[d]);
        end
      end
    end
    evt_valid = 1'b0;
    tick();
    rd_ready = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_random();
    do_clear();
    for (int c = 0; c < 600; c++) begin
      en        = ($urandom_range(0, 15) != 0);
      clear     = ($urandom_range(0, 149) == 0);
      evt_valid = ($urandom_range(0, 9) < 6);
      evt_data  = 16'($urandom);
      rd_ready  = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 7);
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (lvl[d] !== 5'(mq[d].size()) || rv[d] !== (mq[d].size() != 0)) begin
          miscompares++;
          $display("FAIL rand_level c%0d dut%0d: level %0d v %0b expected %0d", c, d, lvl[d], rv[d], mq[d].size());
        end
        if (mq[d].size() != 0) begin
          vectors++;
          if (rdat[d] !== mq[d][0].data || rts[d] !== mq[d][0].ts) begin
            miscompares++;
            $display("FAIL rand_head c%0d dut%0d: got %h ts=%0d expected %h ts=%0d",
                     c, d, rdat[d], rts[d], mq[d][0].data, mq[d][0].ts);
          end
        end
        vectors++;
        if (dcnt[d] !== 16'(mdrop[d]) || stp[d] !== (mmode[d] == 2)) begin
          miscompares++;
          $display("FAIL rand_status c%0d dut%0d: drop %0d stopped %0b expected %0d %0b",
                   c, d, dcnt[d], stp[d], mdrop[d], mmode[d] == 2);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_clear();
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      evt_valid = 1'b1;
      evt_data = 16'(16'h500 + i);
      tick();
    end
    evt_valid = 1'b0;
    vectors++;
    if (lvl[0] !== 5'd5) begin
      miscompares++;
      $display("FAIL mid_pre_level: got %0d expected 5", lvl[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd0 || rv[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_async dut%0d: level %0d rd_valid %0b expected 0 0", d, lvl[d], rv[d]);
      end
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    tick();
    evt_valid = 1'b1;
    evt_data = 16'hBEEF;
    tick();
    evt_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (lvl[d] !== 5'd1 || rdat[d] !== 16'hBEEF || rts[d] !== 32'd0) begin
        miscompares++;
        $display("FAIL mid_resume dut%0d: level %0d data %h ts %0d expected 1 beef 0", d, lvl[d], rdat[d], rts[d]);
      end
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
